// File: rtl/calc2_pkg.sv
// Shared definitions for the two-beat calculator request agent:
// command/response/status codes, tag pool sizing and timeout limits.
package calc2_pkg;

  localparam int NUM_TAGS       = 4;
  localparam int TAG_W          = $clog2(NUM_TAGS);
  localparam int TIMEOUT_CYCLES = 63;
  localparam int AGE_W          = 6;
  localparam int DATA_W         = 32;

  // Calculator command codes (carried through untouched)
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Response codes seen on the calculator response port
  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // Status codes reported downstream
  localparam logic [1:0] STATUS_NONE    = 2'd0;
  localparam logic [1:0] STATUS_OK      = 2'd1;
  localparam logic [1:0] STATUS_ERR     = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    TAG_FREE,
    TAG_OUTSTANDING,
    TAG_DONE
  } tag_state_e;

  typedef enum logic [1:0] {
    ISSUE_IDLE,
    ISSUE_SEND1,
    ISSUE_SEND2
  } issue_state_e;

  // The calculator may return the reserved code 3; it is reported as an error
  function automatic logic [1:0] resp_to_status(input logic [1:0] resp);
    logic [1:0] status;
    case (resp)
      RESP_OK:        status = STATUS_OK;
      RESP_ERR, 2'd3: status = STATUS_ERR;
      default:        status = STATUS_NONE;
    endcase
    return status;
  endfunction

endpackage

// File: rtl/calc2_req_agent_if.sv
// Bundles the upstream request, calculator request/response and
// downstream completion signals of the request agent.
interface calc2_req_agent_if;
  import calc2_pkg::*;

  // upstream request
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_cmd;
  logic [DATA_W-1:0]   in_op1;
  logic [DATA_W-1:0]   in_op2;

  // calculator request port
  logic [3:0]          req_cmd_out;
  logic [DATA_W-1:0]   req_data_out;
  logic [TAG_W-1:0]    req_tag_out;

  // calculator response port
  logic [1:0]          out_resp_in;
  logic [DATA_W-1:0]   out_data_in;
  logic [TAG_W-1:0]    out_tag_in;

  // downstream completion
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_status;
  logic [DATA_W-1:0]   rsp_data;
  logic [TAG_W-1:0]    rsp_tag;

  logic                spurious_err;

  // agent side
  modport slave (
    input  in_valid, in_cmd, in_op1, in_op2,
    input  out_resp_in, out_data_in, out_tag_in,
    input  rsp_ready,
    output in_ready,
    output req_cmd_out, req_data_out, req_tag_out,
    output rsp_valid, rsp_status, rsp_data, rsp_tag,
    output spurious_err
  );

  // environment side (requester, calculator and consumer)
  modport master (
    output in_valid, in_cmd, in_op1, in_op2,
    output out_resp_in, out_data_in, out_tag_in,
    output rsp_ready,
    input  in_ready,
    input  req_cmd_out, req_data_out, req_tag_out,
    input  rsp_valid, rsp_status, rsp_data, rsp_tag,
    input  spurious_err
  );

endinterface

// File: rtl/calc2_tag_entry.sv
// One slot of the tag pool: lifecycle state, age counter for the
// response timeout, and the captured completion status/data.
module calc2_tag_entry
  import calc2_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              rel,
  input  logic              resp_hit,
  input  logic [1:0]        resp_code,
  input  logic [DATA_W-1:0] resp_data,
  output tag_state_e        state,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] data
);

  // The last age value before the timeout fires; the edge that would make
  // the count reach TIMEOUT_CYCLES marks the tag DONE instead.
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

  logic [AGE_W-1:0] age;

  // Slot lifecycle: FREE -> OUTSTANDING -> DONE -> FREE, response beats timeout
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state  <= TAG_FREE;
      age    <= '0;
      status <= STATUS_NONE;
      data   <= '0;
    end else begin
      case (state)
        TAG_FREE: begin
          if (alloc) begin
            state  <= TAG_OUTSTANDING;
            age    <= '0;
            status <= STATUS_NONE;
            data   <= '0;
          end
        end
        TAG_OUTSTANDING: begin
          if (resp_hit) begin
            state  <= TAG_DONE;
            status <= resp_to_status(resp_code);
            data   <= resp_data;
          end else if (age == AGE_LAST) begin
            state  <= TAG_DONE;
            age    <= age + 1'b1;
            status <= STATUS_TIMEOUT;
            data   <= '0;
          end else begin
            age <= age + 1'b1;
          end
        end
        TAG_DONE: begin
          if (rel) begin
            state <= TAG_FREE;
            age   <= '0;
          end
        end
        default: begin
          state <= TAG_FREE;
          age   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/calc2_req_agent.sv
// Request agent: accepts upstream requests, assigns a tag from a pool of
// four, issues each request as two beats to the calculator, tracks
// responses/timeouts per tag and presents completions lowest tag first.
module calc2_req_agent
  import calc2_pkg::*;
(
  input logic              c_clk,
  input logic              reset,
  calc2_req_agent_if.slave bus
);

  issue_state_e      issue_state;
  logic              in_ready_q;
  logic [3:0]        req_cmd_q;
  logic [DATA_W-1:0] req_data_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [DATA_W-1:0] op2_q;
  logic              spurious_q;

  tag_state_e        tag_state  [NUM_TAGS];
  logic [1:0]        tag_status [NUM_TAGS];
  logic [DATA_W-1:0] tag_data   [NUM_TAGS];

  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] done_mask;
  logic [NUM_TAGS-1:0] alloc_vec;
  logic [NUM_TAGS-1:0] rel_vec;
  logic [NUM_TAGS-1:0] hit_vec;
  logic [TAG_W-1:0]    alloc_idx;
  logic [TAG_W-1:0]    present_idx;
  logic                any_done;
  logic                accept;
  logic                release_fire;
  logic                resp_seen;
  logic                spurious_now;
  logic                next_any_free;

  logic [1:0]          rsp_status_c;
  logic [DATA_W-1:0]   rsp_data_c;
  logic [TAG_W-1:0]    rsp_tag_c;

  // Summarise the pool and pick the lowest FREE and lowest DONE tags
  always_comb begin
    free_mask   = '0;
    done_mask   = '0;
    alloc_idx   = '0;
    present_idx = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      free_mask[i] = (tag_state[i] == TAG_FREE);
      done_mask[i] = (tag_state[i] == TAG_DONE);
    end
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_idx = TAG_W'(i);
      if (done_mask[i]) present_idx = TAG_W'(i);
    end
    any_done = |done_mask;
  end

  // Per-tag event strobes for this edge; a response only counts on an OUTSTANDING tag
  always_comb begin
    alloc_vec    = '0;
    rel_vec      = '0;
    hit_vec      = '0;
    resp_seen    = (bus.out_resp_in != RESP_IDLE);
    accept       = bus.in_valid && in_ready_q;
    release_fire = any_done && bus.rsp_ready;
    for (int i = 0; i < NUM_TAGS; i++) begin
      alloc_vec[i] = accept && (alloc_idx == TAG_W'(i));
      rel_vec[i]   = release_fire && (present_idx == TAG_W'(i));
      hit_vec[i]   = resp_seen && (bus.out_tag_in == TAG_W'(i)) &&
                     (tag_state[i] == TAG_OUTSTANDING);
    end
    spurious_now  = resp_seen && (tag_state[bus.out_tag_in] != TAG_OUTSTANDING);
    next_any_free = |((free_mask & ~alloc_vec) | rel_vec);
  end

  for (genvar g = 0; g < NUM_TAGS; g++) begin : g_tag
    calc2_tag_entry u_entry (
      .c_clk     (c_clk),
      .reset     (reset),
      .alloc     (alloc_vec[g]),
      .rel       (rel_vec[g]),
      .resp_hit  (hit_vec[g]),
      .resp_code (bus.out_resp_in),
      .resp_data (bus.out_data_in),
      .state     (tag_state[g]),
      .status    (tag_status[g]),
      .data      (tag_data[g])
    );
  end

  // Issue FSM: two request beats per accepted transaction, registered outputs
  always_ff @(posedge c_clk) begin
    if (reset) begin
      issue_state <= ISSUE_IDLE;
      in_ready_q  <= 1'b0;
      req_cmd_q   <= '0;
      req_data_q  <= '0;
      req_tag_q   <= '0;
      op2_q       <= '0;
    end else begin
      case (issue_state)
        ISSUE_IDLE: begin
          if (accept) begin
            issue_state <= ISSUE_SEND1;
            in_ready_q  <= 1'b0;
            req_cmd_q   <= bus.in_cmd;
            req_data_q  <= bus.in_op1;
            req_tag_q   <= alloc_idx;
            op2_q       <= bus.in_op2;
          end else begin
            in_ready_q  <= next_any_free;
            req_cmd_q   <= '0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
          end
        end
        ISSUE_SEND1: begin
          issue_state <= ISSUE_SEND2;
          in_ready_q  <= 1'b0;
          req_cmd_q   <= '0;
          req_data_q  <= op2_q;
          req_tag_q   <= '0;
        end
        ISSUE_SEND2: begin
          issue_state <= ISSUE_IDLE;
          in_ready_q  <= next_any_free;
          req_cmd_q   <= '0;
          req_data_q  <= '0;
          req_tag_q   <= '0;
        end
        default: begin
          issue_state <= ISSUE_IDLE;
          in_ready_q  <= 1'b0;
          req_cmd_q   <= '0;
          req_data_q  <= '0;
          req_tag_q   <= '0;
        end
      endcase
    end
  end

  // Sticky flag for responses that name a tag nobody is waiting on
  always_ff @(posedge c_clk) begin
    if (reset) begin
      spurious_q <= 1'b0;
    end else if (spurious_now) begin
      spurious_q <= 1'b1;
    end
  end

  // Present the lowest DONE tag; outputs read zero when nothing is complete
  always_comb begin
    rsp_status_c = STATUS_NONE;
    rsp_data_c   = '0;
    rsp_tag_c    = '0;
    if (any_done) begin
      rsp_status_c = tag_status[present_idx];
      rsp_data_c   = tag_data[present_idx];
      rsp_tag_c    = present_idx;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.req_cmd_out  = req_cmd_q;
  assign bus.req_data_out = req_data_q;
  assign bus.req_tag_out  = req_tag_q;
  assign bus.rsp_valid    = any_done;
  assign bus.rsp_status   = rsp_status_c;
  assign bus.rsp_data     = rsp_data_c;
  assign bus.rsp_tag      = rsp_tag_c;
  assign bus.spurious_err = spurious_q;

endmodule
